// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants and sync polarity codes
package vga_timing_pkg;
    localparam int C_H_RES    = 640;
    localparam int C_H_FP     = 16;
    localparam int C_H_PULSE  = 96;
    localparam int C_H_BP     = 48;
    localparam int C_V_RES    = 480;
    localparam int C_V_FP     = 10;
    localparam int C_V_PULSE  = 2;
    localparam int C_V_BP     = 33;
    localparam int C_H_TOTAL  = C_H_RES + C_H_FP + C_H_PULSE + C_H_BP;
    localparam int C_V_TOTAL  = C_V_RES + C_V_FP + C_V_PULSE + C_V_BP;
    localparam int C_SYNC_ACTIVE_LOW  = 0;
    localparam int C_SYNC_ACTIVE_HIGH = 1;

    function automatic logic in_win(logic [10:0] v, logic [10:0] lo, logic [10:0] hi);
        return v >= lo && v < hi;
    endfunction
endpackage

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: wrap counter 0..C_max-1 with enable and carry-out on wrap
module vga_timing_counter #(
    parameter int C_max = 800
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    output logic [9:0] cnt,
    output logic [9:0] cnt_next,
    output logic       carry
);
    localparam logic [9:0] LAST = 10'(C_max - 1);

    logic [9:0] cnt_q, cnt_d;

    always_comb begin
        carry = ena && cnt_q == LAST;
        cnt_d = ena ? (carry ? '0 : cnt_q + 10'd1) : cnt_q;
    end

    always_ff @(posedge clk)
        cnt_q <= reset ? '0 : cnt_d;

    assign cnt      = cnt_q;
    assign cnt_next = cnt_d;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing; every output is registered from the next position
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int C_resolution_x      = C_H_RES,
    parameter int C_hsync_front_porch = C_H_FP,
    parameter int C_hsync_pulse       = C_H_PULSE,
    parameter int C_hsync_back_porch  = C_H_BP,
    parameter int C_resolution_y      = C_V_RES,
    parameter int C_vsync_front_porch = C_V_FP,
    parameter int C_vsync_pulse       = C_V_PULSE,
    parameter int C_vsync_back_porch  = C_V_BP,
    parameter int C_sync_polarity     = C_SYNC_ACTIVE_LOW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       blank,
    output logic       hsync,
    output logic       vsync,
    output logic       fetch_next,
    output logic       frame_start
);
    localparam int H_TOTAL = C_resolution_x + C_hsync_front_porch + C_hsync_pulse + C_hsync_back_porch;
    localparam int V_TOTAL = C_resolution_y + C_vsync_front_porch + C_vsync_pulse + C_vsync_back_porch;
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] RX     = 11'(C_resolution_x);
    localparam logic [10:0] RY     = 11'(C_resolution_y);
    localparam logic [10:0] HS_LO  = 11'(C_resolution_x + C_hsync_front_porch);
    localparam logic [10:0] HS_HI  = 11'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse);
    localparam logic [10:0] VS_LO  = 11'(C_resolution_y + C_vsync_front_porch);
    localparam logic [10:0] VS_HI  = 11'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse);
    localparam logic        POL    = C_sync_polarity[0];

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic [9:0] x_d, y_d, xf, yf;
    logic       h_carry, v_carry;
    logic       blank_q, blank_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic       fetch_next_q, fetch_next_d, frame_start_q, frame_start_d;

    vga_timing_counter #(.C_max(H_TOTAL)) u_h (
        .clk(clk), .reset(reset), .ena(ena),
        .cnt(x), .cnt_next(x_d), .carry(h_carry)
    );

    vga_timing_counter #(.C_max(V_TOTAL)) u_v (
        .clk(clk), .reset(reset), .ena(h_carry),
        .cnt(y), .cnt_next(y_d), .carry(v_carry)
    );

    // Flags hold while ena=0 so the reset values survive until the first advance.
    always_comb begin
        xf            = x_d == H_LAST ? '0 : x_d + 10'd1;
        yf            = x_d == H_LAST ? (y_d == V_LAST ? '0 : y_d + 10'd1) : y_d;
        blank_d       = ena ? !(in_win({1'b0, x_d}, '0, RX) && in_win({1'b0, y_d}, '0, RY)) : blank_q;
        hsync_d       = ena ? (in_win({1'b0, x_d}, HS_LO, HS_HI) ? POL : ~POL) : hsync_q;
        vsync_d       = ena ? (in_win({1'b0, y_d}, VS_LO, VS_HI) ? POL : ~POL) : vsync_q;
        fetch_next_d  = ena ? in_win({1'b0, xf}, '0, RX) && in_win({1'b0, yf}, '0, RY) : fetch_next_q;
        frame_start_d = v_carry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q       <= 1'b0;
            hsync_q       <= ~POL;
            vsync_q       <= ~POL;
            fetch_next_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            blank_q       <= blank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            fetch_next_q  <= fetch_next_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign blank       = blank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign fetch_next  = fetch_next_q;
    assign frame_start = frame_start_q;
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter C_resolution_x, default 640, meaning visible pixels per line.
REQ-002 Parameter C_hsync_front_porch, default 16, meaning pixels from end of visible area to hsync start.
REQ-003 Parameter C_hsync_pulse, default 96, meaning hsync width in pixels.
REQ-004 Parameter C_hsync_back_porch, default 48, meaning pixels from hsync end to line end.
REQ-005 Parameter C_resolution_y, default 480, meaning visible lines per frame.
REQ-006 Parameter C_vsync_front_porch, default 10, meaning lines from end of visible area to vsync start.
REQ-007 Parameter C_vsync_pulse, default 2, meaning vsync width in lines.
REQ-008 Parameter C_vsync_back_porch, default 33, meaning lines from vsync end to frame end.
REQ-009 Parameter C_sync_polarity, default 0, meaning active sync level (0 is active-low).
REQ-010 Port clk, input, 1, pixel clock (25 MHz); one clock; reset is synchronous and active-high.
REQ-011 Port reset, input, 1, synchronous active-high reset.
REQ-012 Port ena, input, 1, pixel advance enable; the timing advances only on cycles where ena=1.
REQ-013 Ports x and y, output, 10 each, current pixel column and line.
REQ-014 Port blank, output, 1, high outside the visible area.
REQ-015 Ports hsync and vsync, output, 1 each, sync pulses with the level set by C_sync_polarity.
REQ-016 Port fetch_next, output, 1, high when the next pixel position is visible (one-pixel prefetch for the upstream generator or memory).
REQ-017 Port frame_start, output, 1, single-cycle pulse at the start of each frame.

Function
REQ-018 Line total H_TOTAL = res_x + hfp + hpulse + hbp; frame total V_TOTAL = res_y + vfp + vpulse + vbp. Defaults are 800 and 525.
REQ-019 Both totals SHALL be ≤1024, enforced by an elaboration-time check.
REQ-020 All outputs are registers updated in the same clk edge, so all outputs always describe the same (x, y) position.
REQ-021 On a clk edge with ena=1:
- x increments by 1.
- When x = H_TOTAL-1, x wraps to 0 and y increments.
- When y = V_TOTAL-1 at the same time, y wraps to 0.
REQ-022 On a clk edge with ena=0, all outputs hold their values, except frame_start, which is forced to 0.
REQ-023 blank = 1 exactly when x ≥ C_resolution_x or y ≥ C_resolution_y.
REQ-024 hsync is active exactly when res_x+hfp ≤ x < res_x+hfp+hpulse; at defaults this is x in 656..751.
REQ-025 vsync is active exactly when res_y+vfp ≤ y < res_y+vfp+vpulse; at defaults this is y in 490..491, for the whole line.
REQ-026 fetch_next = 1 exactly when the position following (x, y) in scan order is visible.
- It goes high at x = H_TOTAL-1 before each visible line.
- It is low at x = res_x-1.
REQ-027 frame_start = 1 for exactly one clk cycle after the advance from (H_TOTAL-1, V_TOTAL-1) to (0, 0).
REQ-028 Output latency is 0 cycles relative to the counter state, because outputs are registered from the next-state values.

Reset
REQ-029 While reset=1 (sampled at clk), the outputs SHALL be set as follows, regardless of ena:
- x=0 and y=0.
- blank=0.
- hsync and vsync at their inactive level.
- fetch_next=0.
- frame_start=0.
REQ-030 Reset asserted mid-line or mid-frame SHALL restart the timing at (0, 0) on the next clk edge, with no frame_start pulse from reset itself.
REQ-031 The first ena cycle after reset SHALL advance the position to (1, 0).

Structure
REQ-032 The default 640x480@60 timing constants and the sync polarity constants SHALL live in shared package vga_timing_pkg, so that downstream stages (effect filters, the HDMI serializer) use the same totals.
REQ-033 One sub-module, vga_timing_counter, SHALL implement a parameterized wrap counter with enable and carry-out; it is instantiated twice, once horizontal and once vertical, with the horizontal carry gating the vertical enable.

Verification
REQ-034 Reset, then ena=1 for 800 cycles: x runs 0..799 then 0; y goes from 0 to 1; hsync is low for exactly 96 cycles starting at x=656; blank is high for x = 640..799.
REQ-035 Run a full frame with ena=1 (420000 cycles): vsync is low on y = 490..491; frame_start pulses exactly once, on the cycle where (x, y) = (0, 0); blank is high for all lines y = 480..524.
REQ-036 Toggle ena=1/0 alternately: every output holds during ena=0 cycles; frame_start width is still 1 clk; the frame period doubles to 840000 cycles.
REQ-037 Assert reset for 1 cycle at (x, y) = (700, 300): the next cycle shows (0, 0) with blank=0, inactive syncs and frame_start=0.
REQ-038 With C_sync_polarity=1, repeat REQ-034: hsync is high for x = 656..751 and low elsewhere.
REQ-039 Check fetch_next at x = 799, y = 524: it is 1; at x = 639, y = 0 it is 0; at x = 799, y = 479 it is 0.
